// File: rtl/popcount_accumulator_pkg.sv
// Shared constants, carry-save vector type and count-width helper for the
// pipelined popcount accumulator.
package popcount_pkg;

    localparam int CELL_IN  = 5;
    localparam int CELL_OUT = 3;
    // Wide enough for any practical IN_W; the top keeps only CNT_W bits of the final add.
    localparam int CSA_W    = 16;

    typedef struct packed {
        logic [CSA_W-1:0] sum;
        logic [CSA_W-1:0] carry;
    } csa_vec_t;

    function automatic int cnt_width(input int in_w);
        return $clog2(in_w + 1);
    endfunction

endpackage

// File: rtl/popcount_accumulator_if.sv
// Stream bundle for the popcount accumulator: input beat channel and result channel.
interface popcount_accumulator_if #(
    parameter int IN_W  = 15,
    parameter int ACC_W = 16
);
    import popcount_pkg::*;

    localparam int CNT_W = cnt_width(IN_W);

    // Both channels: a beat transfers on a rising edge where valid & ready are both 1;
    // the producer holds valid and data steady until that transfer happens.
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_bits;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic [ACC_W-1:0] out_total;
    logic             out_last;
    logic             out_ovf;

    modport master (
        output in_valid, in_bits, in_last, out_ready,
        input  in_ready, out_valid, out_count, out_total, out_last, out_ovf
    );

    modport slave (
        input  in_valid, in_bits, in_last, out_ready,
        output in_ready, out_valid, out_count, out_total, out_last, out_ovf
    );

endinterface

// File: rtl/popcount_accumulator_csa_cell.sv
// One 5:3 counter cell: number of ones among five inputs as a 3-bit weight.
module csa_cell_5to3
    import popcount_pkg::*;
(
    input  logic [CELL_IN-1:0]  i_bits,
    output logic [CELL_OUT-1:0] o_weight
);

    always_comb begin
        o_weight = '0;
        for (int k = 0; k < CELL_IN; k++) begin
            o_weight = o_weight + CELL_OUT'(i_bits[k]);
        end
    end

endmodule

// File: rtl/popcount_accumulator.sv
// Two-stage popcount with per-frame running total. Define ACC_SAT_EN to make
// out_total saturate at all-ones on overflow instead of wrapping.
module popcount_accumulator
    import popcount_pkg::*;
#(
    parameter int IN_W  = 15,
    parameter int ACC_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    popcount_accumulator_if.slave bus
);

    localparam int CNT_W = cnt_width(IN_W);
    localparam int NG    = (IN_W + CELL_IN - 1) / CELL_IN;
    localparam int PAD_W = NG * CELL_IN;
    localparam int SUM_W = ACC_W + 1;

    logic [PAD_W-1:0]    w_padded;
    logic [CELL_OUT-1:0] w_weight [NG];
    csa_vec_t            w_csa;
    logic [CSA_W-1:0]    w_x, w_s_n, w_c_n;

    logic                r_s1_valid;
    csa_vec_t            r_s1_csa;
    logic                r_s1_last;
    logic                r_out_valid;
    logic [CNT_W-1:0]    r_count;
    logic [ACC_W-1:0]    r_acc;
    logic                r_last;
    logic                r_ovf;
    logic                r_frame_start;

    logic                w_s1_adv, w_in_ready, w_accept;
    logic [CNT_W-1:0]    w_count;
    logic [ACC_W-1:0]    w_base, w_total_next;
    logic [SUM_W-1:0]    w_sum_ext;
    logic                w_ovf_next;

    assign w_padded = PAD_W'(bus.in_bits);

    for (genvar g = 0; g < NG; g++) begin : g_cell
        csa_cell_5to3 u_cell (
            .i_bits   (w_padded[g*CELL_IN +: CELL_IN]),
            .o_weight (w_weight[g])
        );
    end

    // Fold the cell weights into one sum/carry pair; no carry propagates in S1.
    always_comb begin
        w_csa = '0;
        w_x   = '0;
        w_s_n = '0;
        w_c_n = '0;
        for (int g = 0; g < NG; g++) begin
            w_x   = CSA_W'(w_weight[g]);
            w_s_n = w_csa.sum ^ w_csa.carry ^ w_x;
            w_c_n = ((w_csa.sum & w_csa.carry) | (w_csa.sum & w_x) | (w_csa.carry & w_x)) << 1;
            w_csa.sum   = w_s_n;
            w_csa.carry = w_c_n;
        end
    end

    assign w_s1_adv   = !r_out_valid | bus.out_ready;
    assign w_in_ready = !rst & !clr & (!r_s1_valid | w_s1_adv);
    assign w_accept   = bus.in_valid & w_in_ready;

    assign w_count    = CNT_W'(r_s1_csa.sum + r_s1_csa.carry);
    assign w_base     = r_frame_start ? '0 : r_acc;
    assign w_sum_ext  = {1'b0, w_base} + SUM_W'(w_count);
    assign w_ovf_next = (!r_frame_start & r_ovf) | w_sum_ext[ACC_W];

`ifdef ACC_SAT_EN
    assign w_total_next = w_ovf_next ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
`else
    assign w_total_next = w_sum_ext[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_csa      <= '0;
            r_s1_last     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_count       <= '0;
            r_acc         <= '0;
            r_last        <= 1'b0;
            r_ovf         <= 1'b0;
            r_frame_start <= 1'b1;
        end else if (clr) begin
            r_s1_valid    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_acc         <= '0;
            r_ovf         <= 1'b0;
            r_frame_start <= 1'b1;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= bus.in_valid;
                if (w_accept) begin
                    r_s1_csa  <= w_csa;
                    r_s1_last <= bus.in_last;
                end
            end
            if (w_s1_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_count       <= w_count;
                    r_acc         <= w_total_next;
                    r_last        <= r_s1_last;
                    r_ovf         <= w_ovf_next;
                    r_frame_start <= r_s1_last;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_count = r_count;
    assign bus.out_total = r_acc;
    assign bus.out_last  = r_last;
    assign bus.out_ovf   = r_ovf;

endmodule

// File: tb/tb_popcount_accumulator.sv
// Directed bench for popcount_accumulator at IN_W=15, ACC_W=8.
module tb_popcount_accumulator;

    localparam int IN_W  = 15;
    localparam int ACC_W = 8;
    localparam int EXP_W = 4 + ACC_W + 2;
`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst;
    logic clr;

    popcount_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

    popcount_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] pk(input int cnt, input int tot, input bit last, input bit ovf);
        logic [31:0] c;
        logic [31:0] t;
        c = cnt;
        t = tot;
        return {c[3:0], t[ACC_W-1:0], last, ovf};
    endfunction

    // scoreboard: every delivered beat must match the head of exp_q
    always @(negedge clk) begin
        logic [EXP_W-1:0] w;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("out_beat", 32'({bus.out_count, bus.out_total, bus.out_last, bus.out_ovf}), 32'(w));
            end
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] bits, input logic last);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bits  = bits;
        bus.in_last  = last;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            cyc();
        end
        bus.in_valid = 1'b0;
        check("accepted", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bits   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // 1: reset held two cycles
        cyc();
        cyc();
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_count", 32'(bus.out_count), 32'd0);
        check("rst_out_total", 32'(bus.out_total), 32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        cyc();

        // 2: all-ones beat, two-cycle latency
        exp_q.push_back(pk(15, 15, 1'b1, 1'b0));
        send(15'h7FFF, 1'b1);
        @(negedge clk);
        check("lat_s1_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("lat_s2_valid", 32'(bus.out_valid), 32'd1);
        drain();

        // 3: back-to-back frame, then a fresh frame
        exp_q.push_back(pk(1, 1, 1'b0, 1'b0));
        exp_q.push_back(pk(2, 3, 1'b0, 1'b0));
        exp_q.push_back(pk(3, 6, 1'b1, 1'b0));
        send(15'h0001, 1'b0);
        send(15'h0003, 1'b0);
        send(15'h0007, 1'b1);
        @(negedge clk);
        check("b2b_valid2", 32'(bus.out_valid), 32'd1);
        check("b2b_count2", 32'(bus.out_count), 32'd2);
        @(negedge clk);
        check("b2b_valid3", 32'(bus.out_valid), 32'd1);
        check("b2b_total3", 32'(bus.out_total), 32'd6);
        drain();
        exp_q.push_back(pk(1, 1, 1'b1, 1'b0));
        send(15'h0001, 1'b1);
        drain();

        // 4: downstream stall for four edges; zero beat included
        exp_q.push_back(pk(5, 5, 1'b0, 1'b0));
        exp_q.push_back(pk(0, 5, 1'b0, 1'b0));
        exp_q.push_back(pk(8, 13, 1'b0, 1'b0));
        exp_q.push_back(pk(15, 28, 1'b1, 1'b0));
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_last   = 1'b0;
        bus.in_bits   = 15'h001F;
        @(negedge clk);
        check("stall_rdy0", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.in_bits = 15'h0000;
        @(negedge clk);
        check("stall_rdy1", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.in_bits = 15'h00FF;
        @(negedge clk);
        check("stall_rdy2",   32'(bus.in_ready),  32'd0);
        check("stall_valid2", 32'(bus.out_valid), 32'd1);
        check("stall_count2", 32'(bus.out_count), 32'd5);
        cyc();
        @(negedge clk);
        check("stall_rdy3",   32'(bus.in_ready),  32'd0);
        check("stall_count3", 32'(bus.out_count), 32'd5);
        check("stall_total3", 32'(bus.out_total), 32'd5);
        cyc();
        bus.out_ready = 1'b1;
        send(15'h00FF, 1'b0);
        send(15'h7FFF, 1'b1);
        drain();

        // 5: 18 all-ones beats; total passes 255 on the last one
        for (int i = 1; i <= 18; i++) begin
            int  run;
            bit  ovf;
            int  tot;
            run = i * 15;
            ovf = (run > 255);
            tot = ovf ? (SAT ? 255 : run % 256) : run;
            exp_q.push_back(pk(15, tot, i == 18, ovf));
            send(15'h7FFF, i == 18);
        end
        drain();

        // 6: flush with two beats in flight and a beat on the input
        bus.out_ready = 1'b0;
        send(15'h000F, 1'b0);
        send(15'h00F0, 1'b0);
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bits  = 15'h7FFF;
        bus.in_last  = 1'b0;
        @(negedge clk);
        check("clr_in_ready", 32'(bus.in_ready), 32'd0);
        cyc();
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("clr_valid0", 32'(bus.out_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("clr_valid1", 32'(bus.out_valid), 32'd0);
        cyc();
        exp_q.push_back(pk(2, 2, 1'b1, 1'b0));
        send(15'h0003, 1'b1);
        drain();
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
